// File: rtl/cache_access_sequencer.sv
// Serialises buffered cache requests: FIFO -> issue -> wait -> capture -> response.
// Define CACHE_SEQ_STATS_EN to build the saturating hit/miss counters.
module cache_access_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_addr,
  input  logic [7:0]           req_wdata,
  input  logic                 req_we,
  output logic [31:0]          cache_addr,
  output logic [7:0]           cache_wr_data,
  output logic                 cache_wr_en,
  input  logic [7:0]           cache_rd_data,
  input  logic                 cache_hit,
  input  logic                 cache_miss,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_hit,
  output logic                 rsp_we,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic                 busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        we;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE_WAIT, S_CAPTURE, S_RESP} state_t;

  req_t          r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  state_t        r_state, w_next;

  logic        w_full, w_empty, w_push, w_pop, w_capture, w_rsp_done;
  req_t        w_head;

  logic [31:0] r_cache_addr;
  logic [7:0]  r_cache_wr_data;
  logic        r_cache_wr_en;
  logic        r_cur_we;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_rdata;
  logic        r_rsp_hit;
  logic        r_rsp_we;

  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = req_valid && !w_full;
  assign w_head  = r_fifo[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= '{addr: req_addr, wdata: req_wdata, we: req_we};
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (!w_empty) w_next = S_ISSUE_WAIT;
      S_ISSUE_WAIT: w_next = S_CAPTURE;
      S_CAPTURE:    w_next = S_RESP;
      S_RESP:       if (rsp_ready) w_next = w_empty ? S_IDLE : S_ISSUE_WAIT;
      default:      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop      = 1'b0;
    w_capture  = 1'b0;
    w_rsp_done = 1'b0;
    case (r_state)
      S_IDLE:    w_pop = !w_empty;
      S_CAPTURE: w_capture = 1'b1;
      S_RESP: begin
        w_rsp_done = rsp_ready;
        w_pop      = rsp_ready && !w_empty;
      end
      default: ;
    endcase
  end

  // Write enable is only ever set on the issuing edge, so writes last one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cache_addr    <= '0;
      r_cache_wr_data <= '0;
      r_cache_wr_en   <= 1'b0;
      r_cur_we        <= 1'b0;
      r_rsp_valid     <= 1'b0;
      r_rsp_rdata     <= '0;
      r_rsp_hit       <= 1'b0;
      r_rsp_we        <= 1'b0;
    end else begin
      if (w_pop) begin
        r_cache_addr    <= w_head.addr;
        r_cache_wr_data <= w_head.wdata;
        r_cache_wr_en   <= w_head.we;
        r_cur_we        <= w_head.we;
      end else begin
        r_cache_wr_en   <= 1'b0;
      end
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= cache_rd_data;
        r_rsp_hit   <= cache_hit;
        r_rsp_we    <= r_cur_we;
      end else if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef CACHE_SEQ_STATS_EN
  logic [CNT_WIDTH-1:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_capture) begin
      if (cache_hit  && !(&r_hit_cnt))  r_hit_cnt  <= r_hit_cnt + 1'b1;
      if (cache_miss && !(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`else
  logic w_unused_miss;
  assign w_unused_miss = cache_miss;
  assign hit_count     = '0;
  assign miss_count    = '0;
`endif

  assign req_ready     = !w_full;
  assign cache_addr    = r_cache_addr;
  assign cache_wr_data = r_cache_wr_data;
  assign cache_wr_en   = r_cache_wr_en;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_hit       = r_rsp_hit;
  assign rsp_we        = r_rsp_we;
  assign busy          = (r_state != S_IDLE) || !w_empty;

endmodule
